// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, the scoreboard entry layout and the select priority helper.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int unsigned SB_W = 5;

    // One scoreboard slot: valid (instruction writes a register),
    // destination register and load flag.
    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic       ld;
    } sb_entry_t;

    // EX/MEM wins over MEM/WB because the EX producer is the younger one.
    function automatic logic [1:0] fwd_sel(input logic hit_e, input logic hit_m);
        if (hit_e) begin
            return FWD_EXMEM;
        end else if (hit_m) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sb_match.sv
// Compares one source register against one scoreboard entry.
module sb_match
    import hazard_ctrl_pkg::*;
(
    input  logic [2:0] src,
    input  sb_entry_t  entry,
    output logic       match,
    output logic       ld
);

    // Match only counts when the entry really writes a register.
    always_comb begin
        match = entry.v & (entry.rd == src);
        ld    = entry.ld;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: scoreboards the EX and MEM
// destinations, stalls decode on unresolvable hazards and registers the
// forwarding selects for the instruction entering EX.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter bit FORWARD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_rs_used,
    input  logic [2:0]  id_rs,
    input  logic        id_rt_used,
    input  logic [2:0]  id_rt,
    input  logic        id_reg_write,
    input  logic [2:0]  id_wr_reg,
    input  logic        id_is_load,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  ex_fwd_a,
    output logic [1:0]  ex_fwd_b,
    output logic [15:0] stall_count
);

    sb_entry_t   e_q;
    sb_entry_t   m_q;
    logic [1:0]  fwd_a_q;
    logic [1:0]  fwd_b_q;
    logic [15:0] cnt_q;

    logic rs_e_match, rs_e_ld, rs_m_match, rs_m_ld;
    logic rt_e_match, rt_e_ld, rt_m_match, rt_m_ld;
    logic rs_hit_e, rs_hit_m, rt_hit_e, rt_hit_m;
    logic hazard, issue;
    logic [1:0] fwd_a_d, fwd_b_d;
    logic unused_m_ld;

    sb_match u_rs_e (.src(id_rs), .entry(e_q), .match(rs_e_match), .ld(rs_e_ld));
    sb_match u_rs_m (.src(id_rs), .entry(m_q), .match(rs_m_match), .ld(rs_m_ld));
    sb_match u_rt_e (.src(id_rt), .entry(e_q), .match(rt_e_match), .ld(rt_e_ld));
    sb_match u_rt_m (.src(id_rt), .entry(m_q), .match(rt_m_match), .ld(rt_m_ld));

    // The MEM-stage load flag never gates a hazard: MEM results are forwardable.
    assign unused_m_ld = rs_m_ld | rt_m_ld;

    // Hazard detection, stall/issue decision and forwarding select computation.
    always_comb begin
        rs_hit_e = id_valid & id_rs_used & rs_e_match;
        rs_hit_m = id_valid & id_rs_used & rs_m_match;
        rt_hit_e = id_valid & id_rt_used & rt_e_match;
        rt_hit_m = id_valid & id_rt_used & rt_m_match;

        if (FORWARD) begin
            hazard = (rs_hit_e & rs_e_ld) | (rt_hit_e & rt_e_ld);
            fwd_a_d = fwd_sel(rs_hit_e, rs_hit_m);
            fwd_b_d = fwd_sel(rt_hit_e, rt_hit_m);
        end else begin
            hazard  = rs_hit_e | rs_hit_m | rt_hit_e | rt_hit_m;
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
        end

        // Flush wins: the instruction that would stall is being killed.
        stall = hazard & ~flush;
        issue = id_valid & ~stall & ~flush;
    end

    // Scoreboard shift, select registers and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q     <= '0;
            m_q     <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            m_q <= e_q;
            if (issue) begin
                e_q     <= '{v: id_reg_write, rd: id_wr_reg, ld: id_is_load};
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end else begin
                e_q     <= '0;
                fwd_a_q <= FWD_RF;
                fwd_b_q <= FWD_RF;
            end
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign ex_fwd_a    = fwd_a_q;
    assign ex_fwd_b    = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl: one instance with forwarding,
// one without, plus hand-written reset and saturation sequences.
module tb_hazard_ctrl;

    typedef struct {
        logic       v;
        logic       rsu;
        logic [2:0] rs;
        logic       rtu;
        logic [2:0] rt;
        logic       rw;
        logic [2:0] wr;
        logic       ld;
        logic       fl;
        logic       exp_st;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic [15:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       v1, rsu1, rtu1, rw1, ld1, fl1;
    logic [2:0] rs1, rt1, wr1;
    logic       v0, rsu0, rtu0, rw0, ld0, fl0;
    logic [2:0] rs0, rt0, wr0;

    logic        st1, st0;
    logic [1:0]  fa1, fb1, fa0, fb0;
    logic [15:0] cnt1, cnt0;

    int n_cmp = 0;
    int n_err = 0;

    vec_t t1[16];
    vec_t t0[15];

    always #5 clk = ~clk;

    hazard_ctrl #(.FORWARD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(v1),
        .id_rs_used(rsu1), .id_rs(rs1), .id_rt_used(rtu1), .id_rt(rt1),
        .id_reg_write(rw1), .id_wr_reg(wr1), .id_is_load(ld1), .flush(fl1),
        .stall(st1), .ex_fwd_a(fa1), .ex_fwd_b(fb1), .stall_count(cnt1)
    );

    hazard_ctrl #(.FORWARD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .id_valid(v0),
        .id_rs_used(rsu0), .id_rs(rs0), .id_rt_used(rtu0), .id_rt(rt0),
        .id_reg_write(rw0), .id_wr_reg(wr0), .id_is_load(ld0), .flush(fl0),
        .stall(st0), .ex_fwd_a(fa0), .ex_fwd_b(fb0), .stall_count(cnt0)
    );

    function automatic vec_t mk(input logic v, input logic rsu, input logic [2:0] rs,
                                input logic rtu, input logic [2:0] rt,
                                input logic rw, input logic [2:0] wr, input logic ld,
                                input logic fl, input logic st, input logic [1:0] a,
                                input logic [1:0] b, input logic [15:0] cnt);
        vec_t x;
        x.v = v; x.rsu = rsu; x.rs = rs; x.rtu = rtu; x.rt = rt;
        x.rw = rw; x.wr = wr; x.ld = ld; x.fl = fl;
        x.exp_st = st; x.exp_a = a; x.exp_b = b; x.exp_cnt = cnt;
        return x;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit which, input vec_t x);
        if (which) begin
            v1 = x.v; rsu1 = x.rsu; rs1 = x.rs; rtu1 = x.rtu; rt1 = x.rt;
            rw1 = x.rw; wr1 = x.wr; ld1 = x.ld; fl1 = x.fl;
        end else begin
            v0 = x.v; rsu0 = x.rsu; rs0 = x.rs; rtu0 = x.rtu; rt0 = x.rt;
            rw0 = x.rw; wr0 = x.wr; ld0 = x.ld; fl0 = x.fl;
        end
    endtask

    // Drive at negedge, check stall before the edge, registered outputs after it.
    task automatic run_vec(input bit which, input vec_t x, input string tag);
        @(negedge clk);
        drive(which, x);
        #1;
        check({tag, " stall"}, which ? 16'(st1) : 16'(st0), 16'(x.exp_st));
        @(posedge clk);
        #1;
        check({tag, " fwd_a"}, which ? 16'(fa1) : 16'(fa0), 16'(x.exp_a));
        check({tag, " fwd_b"}, which ? 16'(fb1) : 16'(fb0), 16'(x.exp_b));
        check({tag, " count"}, which ? cnt1 : cnt0, x.exp_cnt);
    endtask

    initial begin
        vec_t idle;
        vec_t self_dep;

        //          v rsu rs rtu rt rw wr ld fl  st a  b  cnt
        t1[0]  = mk(1, 1, 1, 0, 0, 1, 2, 1, 0,  0, 0, 0, 0);  // load R2
        t1[1]  = mk(1, 1, 2, 1, 0, 1, 3, 0, 0,  1, 0, 0, 1);  // add uses R2: load-use
        t1[2]  = mk(1, 1, 2, 1, 0, 1, 3, 0, 0,  0, 2, 0, 1);  // retry, MEM/WB fwd
        t1[3]  = mk(1, 1, 3, 1, 3, 1, 6, 0, 0,  0, 1, 1, 1);  // sub R3,R3 both 01
        t1[4]  = mk(1, 0, 0, 0, 0, 1, 4, 0, 0,  0, 0, 0, 1);  // write R4
        t1[5]  = mk(1, 0, 0, 0, 0, 1, 4, 0, 0,  0, 0, 0, 1);  // write R4 again
        t1[6]  = mk(1, 1, 4, 1, 5, 0, 4, 0, 0,  0, 1, 0, 1);  // read R4: younger wins
        t1[7]  = mk(1, 1, 4, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1);  // E not writing: M wins
        t1[8]  = mk(1, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 1);  // load R1
        t1[9]  = mk(1, 1, 1, 1, 1, 1, 1, 0, 1,  0, 0, 0, 1);  // reader + flush
        t1[10] = mk(1, 1, 1, 0, 0, 1, 5, 1, 0,  0, 2, 0, 1);  // E was bubbled
        t1[11] = mk(0, 1, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);  // invalid ID
        t1[12] = mk(1, 1, 5, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1);  // load at distance 2
        t1[13] = mk(1, 0, 0, 0, 0, 1, 3, 1, 0,  0, 0, 0, 1);  // load R3
        t1[14] = mk(1, 0, 0, 1, 3, 1, 7, 0, 0,  1, 0, 0, 2);  // rt load-use
        t1[15] = mk(1, 0, 0, 1, 3, 1, 7, 0, 0,  0, 0, 2, 2);  // retry, fwd_b 10

        t0[0]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 0, 0);  // add R5
        t0[1]  = mk(1, 1, 5, 1, 5, 1, 6, 0, 0,  1, 0, 0, 1);  // distance 1
        t0[2]  = mk(1, 1, 5, 1, 5, 1, 6, 0, 0,  1, 0, 0, 2);
        t0[3]  = mk(1, 1, 5, 1, 5, 1, 6, 0, 0,  0, 0, 0, 2);  // issues, selects 00
        t0[4]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 2);
        t0[5]  = mk(1, 1, 6, 0, 0, 0, 0, 0, 0,  1, 0, 0, 3);  // distance 2
        t0[6]  = mk(1, 1, 6, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
        t0[7]  = mk(1, 0, 0, 0, 0, 1, 2, 0, 0,  0, 0, 0, 3);  // write R2
        t0[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
        t0[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
        t0[10] = mk(1, 1, 2, 1, 2, 0, 0, 0, 0,  0, 0, 0, 3);  // distance 3: no stall
        t0[11] = mk(1, 0, 0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 3);
        t0[12] = mk(1, 1, 3, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3);  // flush beats hazard
        t0[13] = mk(1, 1, 3, 0, 0, 0, 0, 0, 0,  1, 0, 0, 4);  // M still matches
        t0[14] = mk(1, 1, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4);

        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        self_dep = mk(1, 1, 5, 1, 5, 1, 5, 0, 0,  0, 0, 0, 0);
        drive(1'b1, idle);
        drive(1'b0, idle);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset stall F1", 16'(st1), 16'd0);
        check("reset fwd_a F1", 16'(fa1), 16'd0);
        check("reset fwd_b F1", 16'(fb1), 16'd0);
        check("reset count F1", cnt1, 16'd0);
        check("reset stall F0", 16'(st0), 16'd0);
        check("reset count F0", cnt0, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(1'b1, t1[i], $sformatf("F1[%0d]", i));
        for (int i = 0; i < 15; i++) run_vec(1'b0, t0[i], $sformatf("F0[%0d]", i));

        // Reset asserted while a FORWARD=0 dependence is stalling.
        run_vec(1'b0, mk(1, 0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 0, 4), "rstmid wr");
        @(negedge clk);
        drive(1'b0, self_dep);
        rst = 1'b1;
        #1;
        check("rstmid stall during rst", 16'(st0), 16'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid stall after rst", 16'(st0), 16'd0);
        check("rstmid count after rst", cnt0, 16'd0);
        @(posedge clk);
        #1;
        check("rstmid fwd_a issue", 16'(fa0), 16'd0);

        // Saturation: preload the counter near the top, then keep stalling
        // well past the remaining headroom (two stalls per three cycles).
        @(negedge clk);
        force dut0.cnt_q = 16'hFFF0;
        drive(1'b0, self_dep);
        @(negedge clk);
        release dut0.cnt_q;
        repeat (60) @(posedge clk);
        #1;
        check("saturate count", cnt0, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        check("saturate hold", cnt0, 16'hFFFF);

        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, idle);
        @(posedge clk);
        #1;
        check("final rst count", cnt0, 16'd0);
        check("final rst fwd_a", 16'(fa0), 16'd0);
        check("final rst fwd_b", 16'(fb0), 16'd0);
        check("final rst stall", 16'(st0), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
